// File: rtl/fp_div_sqrt_iter.sv
// rtl/fp_div_sqrt_iter.sv - radix-2 iterative mantissa divider / square root
// One result bit per cycle, MSB first; shared restoring datapath for both ops.
module fp_div_sqrt_iter #(
  parameter int MANT_W = 24,
  parameter int Q_W    = MANT_W + 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              op_sqrt,
  input  logic              sqrt_odd,
  input  logic              clear,
  input  logic [MANT_W-1:0] mant_a,
  input  logic [MANT_W-1:0] mant_b,
  output logic [Q_W-1:0]    q,
  output logic              sticky,
  output logic              ready,
  output logic              busy
);

  localparam int REM_W = Q_W + 4;
  localparam int X_W   = 2 * Q_W;
  localparam int CNT_W = $clog2(Q_W);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               op_sqrt_q;
  logic [MANT_W-1:0]  b_q;
  logic [X_W-1:0]     x_q;
  logic [REM_W-1:0]   rem_q;
  logic [Q_W-1:0]     acc_q;
  logic [Q_W-1:0]     q_q;
  logic               sticky_q, ready_q, busy_q;

  logic               accept, finish;
  logic [REM_W-1:0]   rem_sh, trial, diff, rem_nxt;
  logic [Q_W-1:0]     acc_nxt;
  logic               take;
  logic [MANT_W:0]    radicand;

  assign accept = (state_q == IDLE) && enable && !clear;
  assign finish = (state_q == ITER) && (cnt_q == '0) && !clear;

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (enable) state_d = ITER;
        ITER:    if (cnt_q == '0) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Sqrt pulls two radicand bits per step and trials against 4*root+1;
  // divide trials against the divisor and doubles the partial remainder.
  always_comb begin
    rem_sh   = op_sqrt_q ? {rem_q[REM_W-3:0], x_q[X_W-1 -: 2]} : rem_q;
    trial    = op_sqrt_q ? {{(REM_W-Q_W-2){1'b0}}, acc_q, 2'b01}
                         : {{(REM_W-MANT_W){1'b0}}, b_q};
    take     = (rem_sh >= trial);
    diff     = take ? (rem_sh - trial) : rem_sh;
    rem_nxt  = op_sqrt_q ? diff : (diff << 1);
    acc_nxt  = {acc_q[Q_W-2:0], take};
    radicand = sqrt_odd ? {mant_a, 1'b0} : {1'b0, mant_a};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      op_sqrt_q <= 1'b0;
      b_q       <= '0;
      x_q       <= '0;
      rem_q     <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      sticky_q  <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      ready_q <= (state_d == DONE);
      busy_q  <= (state_d != IDLE);
      if (accept) begin
        cnt_q     <= CNT_W'(Q_W - 1);
        op_sqrt_q <= op_sqrt;
        b_q       <= mant_b;
        x_q       <= {radicand, {(X_W-MANT_W-1){1'b0}}};
        rem_q     <= op_sqrt ? '0 : {{(REM_W-MANT_W){1'b0}}, mant_a};
        acc_q     <= '0;
      end else if (state_q == ITER) begin
        cnt_q <= cnt_q - 1'b1;
        x_q   <= {x_q[X_W-3:0], 2'b00};
        rem_q <= rem_nxt;
        acc_q <= acc_nxt;
      end
      if (finish) begin
        q_q      <= acc_nxt;
        sticky_q <= (diff != '0);
      end
    end
  end

  assign q      = q_q;
  assign sticky = sticky_q;
  assign ready  = ready_q;
  assign busy   = busy_q;

endmodule

// File: doc/fp_div_sqrt_iter.md
FP_DIV_SQRT_ITER -- requirements
Module: fp_div_sqrt_iter

Interface
REQ-001 SHALL have parameter MANT_W, default 24, meaning mantissa width including the hidden bit.
REQ-002 SHALL have parameter Q_W, default MANT_W+2, meaning root/quotient width: integer bit, 23 fraction bits, guard bit, round bit.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port enable, input, 1, start request; sampled only in IDLE.
REQ-006 SHALL have port op_sqrt, input, 1: 0 = divide a/b, 1 = square root of a.
REQ-007 SHALL have port sqrt_odd, input, 1: for sqrt, 1 = radicand is 2·a (odd unbiased exponent), 0 = radicand is a.
REQ-008 SHALL have port clear, input, 1, synchronous abort.
REQ-009 SHALL have port mant_a, input, MANT_W, dividend/radicand mantissa, 1.23 format.
REQ-010 SHALL have port mant_b, input, MANT_W, divisor mantissa, 1.23 format; ignored for sqrt.
REQ-011 SHALL have port q, output, Q_W, result, 1.25 format.
REQ-012 SHALL have port sticky, output, 1, meaning the remainder is nonzero.
REQ-013 SHALL have port ready, output, 1, one-cycle result-valid pulse.
REQ-014 SHALL have port busy, output, 1, high while not in IDLE.

Function
REQ-015 SHALL implement states IDLE, ITER and DONE.
REQ-016 In IDLE with enable=1 and clear=0 at an edge, the block SHALL capture the operands, op_sqrt and sqrt_odd, load the iteration counter with Q_W-1, and enter ITER.
REQ-017 ITER SHALL produce exactly one result bit per cycle, MSB first, and SHALL enter DONE on the edge where the counter is 0 (Q_W iteration edges in total).
REQ-018 DONE SHALL last exactly one cycle with ready=1, then return to IDLE; ready SHALL be 0 in every other state.
REQ-019 Latency: if enable is accepted at edge E, ready SHALL be registered high at edge E+26 and low at E+27 (default parameters); latency SHALL be independent of operand values and op.
REQ-020 Divide result: q = floor(A·2^25 / B) and sticky = (A·2^25 mod B != 0), where A and B are the mantissas read as integers.
REQ-021 Sqrt result: with X = mant_a·(sqrt_odd ? 2 : 1)·2^27, q = floor(sqrt(X)) and sticky = (q² != X).
REQ-022 Internal remainder width SHALL be sufficient that no iteration overflows (≥ MANT_W+3 bits).
REQ-023 q and sticky SHALL update only on the transition into DONE, and SHALL hold their values until the next such transition.
REQ-024 enable SHALL be ignored in ITER and DONE; no queuing of requests.
REQ-025 Operand inputs SHALL be ignored after capture; changes during ITER SHALL not affect the result.
REQ-026 clear=1 at any edge SHALL force IDLE with no ready pulse and leave q/sticky unchanged; clear has priority over enable.
REQ-027 Illegal operands (mant_a[MSB]=0, or divide with mant_b[MSB]=0) SHALL yield an unspecified q/sticky but SHALL keep the handshake timing identical.
REQ-028 busy SHALL equal (state != IDLE) as a registered output.

Reset
REQ-029 While reset=0, the block SHALL asynchronously force state=IDLE, counter=0, q=0, sticky=0, ready=0, busy=0 and clear all internal registers.
REQ-030 Reset asserted mid-operation SHALL abort with no ready pulse; after release, the block SHALL accept enable on the first edge.

Verification
REQ-031 Divide, a=0x800000, b=0x800000 -> q=0x2000000, sticky=0; ready high exactly at edge E+26 for one cycle.
REQ-032 Divide, a=0x800000, b=0xC00000 -> q=0x1555555, sticky=1.
REQ-033 Sqrt, a=0x800000: sqrt_odd=1 -> q=0x2D413CC, sticky=1; sqrt_odd=0 -> q=0x2000000, sticky=0.
REQ-034 Second enable plus changed operands at E+5 during a divide of 0x800000/0xC00000 -> single ready at E+26, q=0x1555555, and no second ready afterwards.
REQ-035 clear at E+10 -> no ready and q holds its previous value; an enable at the next IDLE edge then completes normally after 26 cycles.
REQ-036 reset low at E+12 -> all outputs 0 immediately; no ready pulse; a new operation after release completes with correct q.
